vga_timing_gen: RTL and testbench

//  VGA 640x480@60 timing generator; first stage of the video path. Divides the system clock to a

---
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 tb/tb_vga_timing_gen.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA timing generator: clock-enable divider, h/v counters, registered sync/blank decode
// and a tick-aligned delay line for the sync/valid copies used by the pixel output stage.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned PIPE_DLY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       pix_ce,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic       valid_d,
    output logic       hsync_d,
    output logic       vsync_d
);
    localparam int unsigned CNT_W        = 10;
    localparam int unsigned CMP_W        = CNT_W + 1;
    localparam int unsigned DIV_W        = $clog2(CLK_DIV);
    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam logic        SYNC_IDLE    = ~SYNC_POL;

    logic [DIV_W-1:0] div_cnt;
    logic             tick_c;
    logic [CNT_W-1:0] h_nxt_c;
    logic [CNT_W-1:0] v_nxt_c;
    logic             valid_nxt_c;
    logic             hsync_nxt_c;
    logic             vsync_nxt_c;

    assign tick_c = en && (div_cnt == DIV_W'(CLK_DIV - 1));

    // Next counter position and its decode, so the registered decode never lags the counters.
    always_comb begin
        h_nxt_c = h_cnt + CNT_W'(1);
        v_nxt_c = v_cnt;
        if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
            h_nxt_c = '0;
            v_nxt_c = (v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt + CNT_W'(1);
        end
        valid_nxt_c = ({1'b0, h_nxt_c} < CMP_W'(H_ACTIVE)) &&
                      ({1'b0, v_nxt_c} < CMP_W'(V_ACTIVE));
        hsync_nxt_c = (({1'b0, h_nxt_c} >= CMP_W'(H_SYNC_START)) &&
                       ({1'b0, h_nxt_c} <  CMP_W'(H_SYNC_END))) ? SYNC_POL : SYNC_IDLE;
        vsync_nxt_c = (({1'b0, v_nxt_c} >= CMP_W'(V_SYNC_START)) &&
                       ({1'b0, v_nxt_c} <  CMP_W'(V_SYNC_END))) ? SYNC_POL : SYNC_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            h_cnt       <= CNT_W'(H_TOTAL - 1);
            v_cnt       <= CNT_W'(V_TOTAL - 1);
            valid       <= 1'b0;
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
            pix_ce      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_ce      <= tick_c;
            line_start  <= tick_c && (h_nxt_c == '0);
            frame_start <= tick_c && (h_nxt_c == '0) && (v_nxt_c == '0);
            if (en) begin
                div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
            end
            if (tick_c) begin
                h_cnt <= h_nxt_c;
                v_cnt <= v_nxt_c;
                valid <= valid_nxt_c;
                hsync <= hsync_nxt_c;
                vsync <= vsync_nxt_c;
            end
        end
    end

    // Delay line advances with the pixel tick, matching the frame-buffer read latency.
    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign valid_d = valid;
            assign hsync_d = hsync;
            assign vsync_d = vsync;
        end else begin : g_dly
            logic [2:0] dly [PIPE_DLY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DLY; i++) begin
                        dly[i] <= {1'b0, SYNC_IDLE, SYNC_IDLE};
                    end
                end else if (tick_c) begin
                    dly[0] <= {valid, hsync, vsync};
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end

            assign {valid_d, hsync_d, vsync_d} = dly[PIPE_DLY-1];
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance and a tiny-raster instance share
// rst/en; both are compared every clock against a raster-position reference model.
module tb_vga_timing_gen;
    localparam int CD [2] = '{4, 3};
    localparam int HA [2] = '{640, 10};
    localparam int HF [2] = '{16, 2};
    localparam int HS [2] = '{96, 3};
    localparam int HB [2] = '{48, 4};
    localparam int VA [2] = '{480, 6};
    localparam int VF [2] = '{10, 1};
    localparam int VS [2] = '{2, 2};
    localparam int VB [2] = '{33, 2};
    localparam int PD [2] = '{2, 0};
    localparam bit POL [2] = '{1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    always #5 clk = ~clk;

    logic       pix_ce [2];
    logic [9:0] h_cnt [2];
    logic [9:0] v_cnt [2];
    logic       valid [2];
    logic       hsync [2];
    logic       vsync [2];
    logic       line_start [2];
    logic       frame_start [2];
    logic       valid_d [2];
    logic       hsync_d [2];
    logic       vsync_d [2];

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst), .en(en), .pix_ce(pix_ce[0]), .h_cnt(h_cnt[0]), .v_cnt(v_cnt[0]),
        .valid(valid[0]), .hsync(hsync[0]), .vsync(vsync[0]), .line_start(line_start[0]),
        .frame_start(frame_start[0]), .valid_d(valid_d[0]), .hsync_d(hsync_d[0]), .vsync_d(vsync_d[0])
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1), .PIPE_DLY(0)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .pix_ce(pix_ce[1]), .h_cnt(h_cnt[1]), .v_cnt(v_cnt[1]),
        .valid(valid[1]), .hsync(hsync[1]), .vsync(vsync[1]), .line_start(line_start[1]),
        .frame_start(frame_start[1]), .valid_d(valid_d[1]), .hsync_d(hsync_d[1]), .vsync_d(vsync_d[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int c, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cfg%0d: got %0d, expected %0d (t=%0t)", name, c, act, exp, $time);
        end
    endtask

    // Reference model: raster position p = v*H_TOTAL + h, advanced once per CLK_DIV enabled clocks.
    int         m_div [2];
    int         m_p [2];
    bit         m_tick [2];
    logic [2:0] m_hist [2][8];

    function automatic int htot(input int c);
        return HA[c] + HF[c] + HS[c] + HB[c];
    endfunction

    function automatic int vtot(input int c);
        return VA[c] + VF[c] + VS[c] + VB[c];
    endfunction

    function automatic logic [2:0] decode(input int c, input int p);
        int   hh, vv;
        logic vl, hs, vs;
        hh = p % htot(c);
        vv = p / htot(c);
        vl = (hh < HA[c]) && (vv < VA[c]);
        hs = (hh >= HA[c] + HF[c] && hh < HA[c] + HF[c] + HS[c]) ? POL[c] : !POL[c];
        vs = (vv >= VA[c] + VF[c] && vv < VA[c] + VF[c] + VS[c]) ? POL[c] : !POL[c];
        return {vl, hs, vs};
    endfunction

    task automatic model_reset(input int c);
        m_div[c]  = 0;
        m_p[c]    = htot(c) * vtot(c) - 1;
        m_tick[c] = 1'b0;
        for (int i = 0; i < 8; i++) m_hist[c][i] = {1'b0, !POL[c], !POL[c]};
    endtask

    task automatic model_step(input int c);
        m_tick[c] = 1'b0;
        if (en) begin
            if (m_div[c] == CD[c] - 1) begin
                m_tick[c] = 1'b1;
                m_div[c]  = 0;
                m_p[c]    = (m_p[c] + 1) % (htot(c) * vtot(c));
                for (int i = 0; i < PD[c]; i++) m_hist[c][i] = m_hist[c][i+1];
                m_hist[c][PD[c]] = decode(c, m_p[c]);
            end else begin
                m_div[c]++;
            end
        end
    endtask

    logic [2:0] ck_cur, ck_dly;
    int         ck_h, ck_v;

    always @(posedge clk) begin
        #1;
        for (int c = 0; c < 2; c++) begin
            if (rst) model_reset(c);
            else     model_step(c);
            ck_cur = m_hist[c][PD[c]];
            ck_dly = m_hist[c][0];
            ck_h   = m_p[c] % htot(c);
            ck_v   = m_p[c] / htot(c);
            check("h_cnt", c, int'(h_cnt[c]), ck_h);
            check("v_cnt", c, int'(v_cnt[c]), ck_v);
            check("valid", c, int'(valid[c]), int'(ck_cur[2]));
            check("hsync", c, int'(hsync[c]), int'(ck_cur[1]));
            check("vsync", c, int'(vsync[c]), int'(ck_cur[0]));
            check("pix_ce", c, int'(pix_ce[c]), int'(m_tick[c]));
            check("line_start", c, int'(line_start[c]), int'(m_tick[c] && ck_h == 0));
            check("frame_start", c, int'(frame_start[c]), int'(m_tick[c] && m_p[c] == 0));
            check("valid_d", c, int'(valid_d[c]), int'(ck_dly[2]));
            check("hsync_d", c, int'(hsync_d[c]), int'(ck_dly[1]));
            check("vsync_d", c, int'(vsync_d[c]), int'(ck_dly[0]));
        end
    end

    task automatic wait_clk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t_hf, t_hr, h_hf, h_hr, t_vf, t_vdf, h_vf, ls1, ls2, viol, cnt_fs, cnt_vs;
        bit   found;
        logic p_hs, p_vl, p_vd;

        rst = 1'b1;
        en  = 1'b0;
        repeat (3) wait_clk();
        check("rst_h", 0, int'(h_cnt[0]), 799);
        check("rst_v", 0, int'(v_cnt[0]), 524);
        check("rst_hsync", 0, int'(hsync[0]), 1);
        check("rst_valid", 0, int'(valid[0]), 0);
        check("rst_h", 1, int'(h_cnt[1]), 18);
        check("rst_vsync", 1, int'(vsync[1]), 0);

        // First tick lands on the CLK_DIV-th edge after release.
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        wait_clk();
        wait_clk();
        check("pre_tick_h", 0, int'(h_cnt[0]), 799);
        check("pre_tick_pix_ce", 0, int'(pix_ce[0]), 0);
        wait_clk();
        check("first_tick_h", 1, int'(h_cnt[1]), 0);
        check("first_tick_frame_start", 1, int'(frame_start[1]), 1);
        check("pre_tick_h3", 0, int'(h_cnt[0]), 799);
        wait_clk();
        check("first_tick_h", 0, int'(h_cnt[0]), 0);
        check("first_tick_v", 0, int'(v_cnt[0]), 0);
        check("first_tick_valid", 0, int'(valid[0]), 1);
        check("first_tick_pix_ce", 0, int'(pix_ce[0]), 1);
        check("first_tick_line_start", 0, int'(line_start[0]), 1);
        check("first_tick_frame_start", 0, int'(frame_start[0]), 1);
        wait_clk();
        check("pulse_width_pix_ce", 0, int'(pix_ce[0]), 0);
        check("pulse_width_frame_start", 0, int'(frame_start[0]), 0);
        repeat (3) wait_clk();
        check("second_tick_h", 0, int'(h_cnt[0]), 1);

        // Line-level timing of the full-size raster.
        t_hf = -1; t_hr = -1; h_hf = -1; h_hr = -1; t_vf = -1; t_vdf = -1; h_vf = -1;
        ls1 = -1; ls2 = -1;
        for (int t = 0; t < 7000; t++) begin
            p_hs = hsync[0];
            p_vl = valid[0];
            p_vd = valid_d[0];
            wait_clk();
            if (p_hs && !hsync[0] && t_hf < 0) begin t_hf = t; h_hf = int'(h_cnt[0]); end
            if (!p_hs && hsync[0] && t_hf >= 0 && t_hr < 0) begin t_hr = t; h_hr = int'(h_cnt[0]); end
            if (p_vl && !valid[0] && t_vf < 0) begin t_vf = t; h_vf = int'(h_cnt[0]); end
            if (p_vd && !valid_d[0] && t_vf >= 0 && t_vdf < 0) t_vdf = t;
            if (line_start[0]) begin
                if (ls1 < 0) ls1 = t;
                else if (ls2 < 0) ls2 = t;
            end
        end
        check("hsync_fall_h", 0, h_hf, 656);
        check("hsync_rise_h", 0, h_hr, 752);
        check("hsync_low_clks", 0, t_hr - t_hf, 384);
        check("valid_fall_h", 0, h_vf, 640);
        check("valid_d_lag_clks", 0, t_vdf - t_vf, 8);
        check("line_period_clks", 0, ls2 - ls1, 3200);

        // Enable pause at h=100.
        found = 1'b0;
        for (int t = 0; t < 4000 && !found; t++) begin
            wait_clk();
            if (h_cnt[0] == 10'd100 && pix_ce[0]) found = 1'b1;
        end
        check("find_h100", 0, int'(found), 1);
        @(negedge clk);
        en   = 1'b0;
        viol = 0;
        repeat (37) begin
            wait_clk();
            if (h_cnt[0] != 10'd100 || pix_ce[0] || line_start[0] || frame_start[0]) viol++;
        end
        check("hold_violations", 0, viol, 0);
        @(negedge clk);
        en    = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            wait_clk();
            if (h_cnt[0] != 10'd100) found = 1'b1;
        end
        check("resume_h", 0, int'(h_cnt[0]), 101);

        // Random enable gaps; the per-cycle model comparison covers this phase.
        repeat (6000) begin
            @(negedge clk);
            en = ($urandom_range(0, 7) != 0);
        end
        @(negedge clk);
        en = 1'b1;

        // Whole frames of the small raster.
        found = 1'b0;
        for (int t = 0; t < 1000 && !found; t++) begin
            wait_clk();
            if (frame_start[1]) found = 1'b1;
        end
        check("find_frame_b", 1, int'(found), 1);
        cnt_fs = 0;
        cnt_vs = 0;
        for (int t = 1; t <= 1881; t++) begin
            wait_clk();
            if (frame_start[1]) cnt_fs++;
            if (vsync[1]) cnt_vs++;
        end
        check("frames_in_1881_clks", 1, cnt_fs, 3);
        check("vsync_active_clks", 1, cnt_vs, 342);

        // Asynchronous reset mid-frame, away from any clock edge.
        found = 1'b0;
        for (int t = 0; t < 700 && !found; t++) begin
            wait_clk();
            if (v_cnt[1] == 10'd4) found = 1'b1;
        end
        check("find_v4", 1, int'(found), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_h", 0, int'(h_cnt[0]), 799);
        check("arst_v", 0, int'(v_cnt[0]), 524);
        check("arst_hsync", 0, int'(hsync[0]), 1);
        check("arst_valid_d", 0, int'(valid_d[0]), 0);
        check("arst_h", 1, int'(h_cnt[1]), 18);
        check("arst_v", 1, int'(v_cnt[1]), 10);
        check("arst_valid", 1, int'(valid[1]), 0);
        check("arst_vsync", 1, int'(vsync[1]), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) wait_clk();
        check("rerun_first_tick_h", 1, int'(h_cnt[1]), 0);
        check("rerun_frame_start", 1, int'(frame_start[1]), 1);
        wait_clk();
        check("rerun_frame_start", 0, int'(frame_start[0]), 1);
        check("rerun_first_tick_h", 0, int'(h_cnt[0]), 0);
        repeat (200) wait_clk();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
